// File: rtl/arm_alu_if.sv
// Operand, control and result bundle for the ARM data-processing ALU.
// The master drives the operands and controls. The slave returns the registered result and flags.
interface arm_alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        cin;
    logic [2:0]  shift_op;
    logic [7:0]  shift_num;
    logic [31:0] out;
    logic        nout;
    logic        zout;
    logic        cout;
    logic        vout;

    modport master (
        output a, b, op, cin, shift_op, shift_num,
        input  out, nout, zout, cout, vout
    );

    modport slave (
        input  a, b, op, cin, shift_op, shift_num,
        output out, nout, zout, cout, vout
    );
endinterface

// File: rtl/arm_alu.sv
// ARM data-processing ALU. A combinational barrel shifter on b feeds the adder and logic unit.
// The result and the NZCV flags are registered with one cycle of latency.
module arm_alu (
    input  logic       CP,
    input  logic       reset,
    arm_alu_if.slave   bus
);

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_type_e;

    typedef enum logic [3:0] {
        OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
        OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
    } alu_op_e;

    shift_type_e shift_type;
    alu_op_e     alu_op;
    logic        by_reg;
    logic [7:0]  amt;
    logic [4:0]  amt5;
    logic        normal_shift;
    logic [32:0] lsl_ext;
    logic [32:0] lsr_ext;
    logic [32:0] asr_ext;
    logic [63:0] ror_ext;
    logic [31:0] op2;
    logic        sh_carry;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_c;
    logic        is_arith;
    logic [32:0] sum;
    logic [31:0] result;
    logic        next_c;
    logic        next_v;

    assign shift_type = shift_type_e'(bus.shift_op[2:1]);
    assign by_reg     = bus.shift_op[0];
    assign amt        = bus.shift_num;
    assign amt5       = bus.shift_num[4:0];
    assign alu_op     = alu_op_e'(bus.op);

    // Shifts of 1..31 share one path for immediate and register forms; the extra bit is the carry-out
    assign normal_shift = by_reg ? (amt != 8'd0 && amt < 8'd32) : (amt5 != 5'd0);
    assign lsl_ext = {1'b0, bus.b} << amt5;
    assign lsr_ext = {bus.b, 1'b0} >> amt5;
    assign asr_ext = $unsigned($signed({bus.b, 1'b0}) >>> amt5);
    assign ror_ext = {bus.b, bus.b} >> amt5;

    always_comb begin
        op2      = bus.b;
        sh_carry = bus.cin;
        unique case (shift_type)
            SH_LSL: begin
                if (normal_shift) begin
                    {sh_carry, op2} = lsl_ext;
                end else if (by_reg && amt == 8'd32) begin
                    op2      = 32'd0;
                    sh_carry = bus.b[0];
                end else if (by_reg && amt > 8'd32) begin
                    op2      = 32'd0;
                    sh_carry = 1'b0;
                end
            end
            SH_LSR: begin
                if (normal_shift) begin
                    {op2, sh_carry} = lsr_ext;
                end else if (!by_reg || amt == 8'd32) begin
                    op2      = 32'd0;
                    sh_carry = bus.b[31];
                end else if (amt != 8'd0) begin
                    op2      = 32'd0;
                    sh_carry = 1'b0;
                end
            end
            SH_ASR: begin
                if (normal_shift) begin
                    {op2, sh_carry} = asr_ext;
                end else if (!by_reg || amt != 8'd0) begin
                    op2      = {32{bus.b[31]}};
                    sh_carry = bus.b[31];
                end
            end
            SH_ROR: begin
                if (amt5 != 5'd0) begin
                    op2      = ror_ext[31:0];
                    sh_carry = ror_ext[31];
                end else if (!by_reg) begin
                    op2      = {bus.cin, bus.b[31:1]};
                    sh_carry = bus.b[0];
                end else if (amt != 8'd0) begin
                    sh_carry = bus.b[31];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        add_x    = bus.a;
        add_y    = op2;
        add_c    = 1'b0;
        is_arith = 1'b1;
        unique case (alu_op)
            OP_SUB, OP_CMP: begin add_y = ~op2; add_c = 1'b1; end
            OP_RSB:         begin add_x = op2; add_y = ~bus.a; add_c = 1'b1; end
            OP_ADD, OP_CMN: ;
            OP_ADC:         add_c = bus.cin;
            OP_SBC:         begin add_y = ~op2; add_c = bus.cin; end
            OP_RSC:         begin add_x = op2; add_y = ~bus.a; add_c = bus.cin; end
            default:        is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_c};

    always_comb begin
        result = sum[31:0];
        unique case (alu_op)
            OP_AND, OP_TST: result = bus.a & op2;
            OP_EOR, OP_TEQ: result = bus.a ^ op2;
            OP_ORR:         result = bus.a | op2;
            OP_MOV:         result = op2;
            OP_BIC:         result = bus.a & ~op2;
            OP_MVN:         result = ~op2;
            default:        ;
        endcase
    end

    // Logical ops take C from the shifter and leave V untouched
    assign next_c = is_arith ? sum[32] : sh_carry;
    assign next_v = is_arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : bus.vout;

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            bus.out  <= 32'd0;
            bus.nout <= 1'b0;
            bus.zout <= 1'b0;
            bus.cout <= 1'b0;
            bus.vout <= 1'b0;
        end else begin
            bus.out  <= result;
            bus.nout <= result[31];
            bus.zout <= (result == 32'd0);
            bus.cout <= next_c;
            bus.vout <= next_v;
        end
    end

endmodule

// File: tb/tb_arm_alu.sv
// Directed bench for arm_alu. Each step drives one operation and checks the registered result and NZCV flags.
module tb_arm_alu;

    logic CP;
    logic reset;
    int   compared;
    int   mismatched;

    arm_alu_if bus ();

    arm_alu dut (
        .CP    (CP),
        .reset (reset),
        .bus   (bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic [2:0] shift_op, input logic [7:0] shift_num);
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.shift_op  = shift_op;
        bus.shift_num = shift_num;
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic [2:0] shift_op, input logic [7:0] shift_num);
        set_inputs(op, a, b, cin, shift_op, shift_num);
        @(posedge CP);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] exp_out, input logic [3:0] exp_nzcv);
        logic [3:0] nzcv;
        nzcv = {bus.nout, bus.zout, bus.cout, bus.vout};
        compared++;
        assert (bus.out === exp_out) else begin
            mismatched++;
            $error("[TB] FAIL %s out: observed %h expected %h", tag, bus.out, exp_out);
        end
        compared++;
        assert (nzcv === exp_nzcv) else begin
            mismatched++;
            $error("[TB] FAIL %s nzcv: observed %b expected %b", tag, nzcv, exp_nzcv);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        set_inputs(4'd4, 32'd1, 32'd1, 1'b0, 3'd0, 8'd0);
        #2 reset = 1'b0;
        @(posedge CP);
        @(posedge CP);
        #1 check_output("reset_hold", 32'd0, 4'b0000);
        @(negedge CP);
        reset = 1'b1;
        #1 check_output("release_no_edge", 32'd0, 4'b0000);
        @(posedge CP);
        #1 check_output("first_edge", 32'd2, 4'b0000);

        apply_stimulus(4'd4, 32'hFFFFFFFF, 32'd1, 1'b0, 3'd0, 8'd0);
        check_output("add_wrap", 32'd0, 4'b0110);
        apply_stimulus(4'd2, 32'd0, 32'd1, 1'b0, 3'd0, 8'd0);
        check_output("sub_borrow", 32'hFFFFFFFF, 4'b1000);
        apply_stimulus(4'd4, 32'h7FFFFFFF, 32'd1, 1'b0, 3'd0, 8'd0);
        check_output("add_ovf", 32'h80000000, 4'b1001);
        apply_stimulus(4'd13, 32'd0, 32'h80000000, 1'b0, 3'd2, 8'd0);
        check_output("mov_lsr32", 32'd0, 4'b0111);
        apply_stimulus(4'd13, 32'd0, 32'd1, 1'b1, 3'd6, 8'd0);
        check_output("mov_rrx", 32'h80000000, 4'b1011);
        apply_stimulus(4'd13, 32'd0, 32'h000000F0, 1'b1, 3'd1, 8'd40);
        check_output("reg_lsl40", 32'd0, 4'b0101);
        apply_stimulus(4'd13, 32'd0, 32'h000000F0, 1'b1, 3'd1, 8'd0);
        check_output("reg_lsl0", 32'h000000F0, 4'b0011);
        apply_stimulus(4'd0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 3'd0, 8'd4);
        check_output("and_lsl4", 32'hF000F000, 4'b1001);
        apply_stimulus(4'd1, 32'hFFFFFFFF, 32'h80000001, 1'b0, 3'd6, 8'd1);
        check_output("eor_ror1", 32'h3FFFFFFF, 4'b0011);
        apply_stimulus(4'd13, 32'd0, 32'h80000000, 1'b0, 3'd4, 8'd0);
        check_output("mov_asr32", 32'hFFFFFFFF, 4'b1011);
        apply_stimulus(4'd13, 32'd0, 32'h40000000, 1'b1, 3'd5, 8'd40);
        check_output("reg_asr40", 32'd0, 4'b0101);
        apply_stimulus(4'd13, 32'd0, 32'h80000010, 1'b1, 3'd5, 8'd4);
        check_output("reg_asr4", 32'hF8000001, 4'b1001);
        apply_stimulus(4'd13, 32'd0, 32'd1, 1'b0, 3'd1, 8'd32);
        check_output("reg_lsl32", 32'd0, 4'b0111);
        apply_stimulus(4'd13, 32'd0, 32'h80000000, 1'b0, 3'd3, 8'd32);
        check_output("reg_lsr32", 32'd0, 4'b0111);
        apply_stimulus(4'd13, 32'd0, 32'h0000001F, 1'b0, 3'd3, 8'd4);
        check_output("reg_lsr4", 32'd1, 4'b0011);
        apply_stimulus(4'd13, 32'd0, 32'h80000000, 1'b0, 3'd7, 8'd32);
        check_output("reg_ror32", 32'h80000000, 4'b1011);
        apply_stimulus(4'd13, 32'd0, 32'h0000000F, 1'b0, 3'd7, 8'd36);
        check_output("reg_ror36", 32'hF0000000, 4'b1011);

        apply_stimulus(4'd6, 32'd5, 32'd3, 1'b0, 3'd0, 8'd0);
        check_output("sbc", 32'd1, 4'b0010);
        apply_stimulus(4'd13, 32'd0, 32'h00000018, 1'b0, 3'd2, 8'd4);
        check_output("imm_lsr4", 32'd1, 4'b0010);
        apply_stimulus(4'd3, 32'd3, 32'd5, 1'b0, 3'd0, 8'd0);
        check_output("rsb", 32'd2, 4'b0010);
        apply_stimulus(4'd7, 32'd5, 32'd3, 1'b1, 3'd0, 8'd0);
        check_output("rsc", 32'hFFFFFFFE, 4'b1000);
        apply_stimulus(4'd5, 32'h80000000, 32'h80000000, 1'b1, 3'd0, 8'd0);
        check_output("adc_ovf", 32'd1, 4'b0011);
        apply_stimulus(4'd10, 32'd5, 32'd5, 1'b0, 3'd0, 8'd0);
        check_output("cmp_eq", 32'd0, 4'b0110);
        apply_stimulus(4'd8, 32'h000000F0, 32'h0000000F, 1'b0, 3'd0, 8'd0);
        check_output("tst", 32'd0, 4'b0100);
        apply_stimulus(4'd9, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 3'd0, 8'd0);
        check_output("teq", 32'd0, 4'b0100);
        apply_stimulus(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3'd0, 8'd0);
        check_output("cmn", 32'hFFFFFFFE, 4'b1010);
        apply_stimulus(4'd12, 32'h0000000F, 32'h000000F0, 1'b0, 3'd0, 8'd0);
        check_output("orr", 32'h000000FF, 4'b0000);
        apply_stimulus(4'd14, 32'h000000FF, 32'h0000000F, 1'b0, 3'd0, 8'd0);
        check_output("bic", 32'h000000F0, 4'b0000);
        apply_stimulus(4'd15, 32'd0, 32'd0, 1'b0, 3'd0, 8'd0);
        check_output("mvn", 32'hFFFFFFFF, 4'b1000);

        apply_stimulus(4'd4, 32'h10, 32'h20, 1'b0, 3'd0, 8'd0);
        check_output("pre_reset", 32'h30, 4'b0000);
        set_inputs(4'd4, 32'hFFFFFFFF, 32'd1, 1'b0, 3'd0, 8'd0);
        #2 reset = 1'b0;
        #1 check_output("async_clear", 32'd0, 4'b0000);
        @(posedge CP);
        #1 check_output("held_in_reset", 32'd0, 4'b0000);
        @(negedge CP);
        reset = 1'b1;
        @(posedge CP);
        #1 check_output("after_rerelease", 32'd0, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
